// File: rtl/stream_xbar_pkg.sv
// Shared helpers and build-mode constant for the stream_xbar crossbar.
// Build macro STREAM_XBAR_DROP_EN selects dropping (instead of wrapping) of out-of-range destinations.
package stream_xbar_pkg;

   typedef enum logic {
      WRAP = 1'b0,
      DROP = 1'b1
   } drop_mode_e;

`ifdef STREAM_XBAR_DROP_EN
   localparam drop_mode_e DROP_MODE = DROP;
`else
   localparam drop_mode_e DROP_MODE = WRAP;
`endif

   function automatic int dest_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // dest never exceeds 2**clog2(n)-1 < 2n, so one subtraction always lands in range
   function automatic int eff_dest(input int dest, input int num_out);
      return (dest < num_out) ? dest : dest - num_out;
   endfunction

endpackage

// File: rtl/stream_xbar_arb.sv
// Per-output round-robin arbiter: grants the first requester at or after ptr, wrapping.
// ptr moves to one past the granted index only when the grant is consumed (adv_i).
module xbar_rr_arb
   import stream_xbar_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = dest_w(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               adv_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if (adv_i) begin
         if (int'(gnt_idx_o) == NUM_REQ - 1) ptr <= '0;
         else                                ptr <= gnt_idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/stream_xbar.sv
// Registered NUM_IN x NUM_OUT stream crossbar with per-output round-robin arbitration.
// Build macro STREAM_XBAR_DROP_EN: out-of-range destinations are dropped (drop_o) instead of wrapped.
//
// Handshake: a beat moves on a channel when valid && ready at a rising clk edge;
// producers hold data/dest while valid && !ready, and in_ready_o is combinational.
module stream_xbar
   import stream_xbar_pkg::*;
#(
   parameter  int ELEM_WIDTH = 8,
   parameter  int NUM_IN     = 4,
   parameter  int NUM_OUT    = 6,
   localparam int DEST_W     = dest_w(NUM_OUT),
   localparam int SRC_W      = dest_w(NUM_IN)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NUM_IN-1:0][ELEM_WIDTH-1:0]    in_data_i,
   input  logic [NUM_IN-1:0][DEST_W-1:0]        in_dest_i,
   input  logic [NUM_IN-1:0]                    in_valid_i,
   output logic [NUM_IN-1:0]                    in_ready_o,
   output logic [NUM_OUT-1:0][ELEM_WIDTH-1:0]   out_data_o,
   output logic [NUM_OUT-1:0][SRC_W-1:0]        out_src_o,
   output logic [NUM_OUT-1:0]                   out_valid_o,
   input  logic [NUM_OUT-1:0]                   out_ready_i,
   output logic                                 drop_o
);

   logic [NUM_IN-1:0][DEST_W-1:0]  eff_d;
   logic [NUM_IN-1:0]              routed;
   logic [NUM_IN-1:0]              dropped;
   logic [NUM_IN-1:0]              granted;
   logic [NUM_OUT-1:0][NUM_IN-1:0] req;
   logic [NUM_OUT-1:0][NUM_IN-1:0] gnt;
   logic [NUM_OUT-1:0][SRC_W-1:0]  gnt_idx;
   logic [NUM_OUT-1:0]             load_ok;
   logic [NUM_OUT-1:0]             xfer;

   always_comb begin
      eff_d = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         eff_d[i] = DEST_W'(eff_dest(int'(in_dest_i[i]), NUM_OUT));
      end
   end

   // Dropped beats are accepted on their own and never reach an arbiter
   if (DROP_MODE == DROP) begin : g_drop
      logic [NUM_IN-1:0] oor;
      always_comb begin
         oor = '0;
         for (int i = 0; i < NUM_IN; i++) begin
            oor[i] = int'(in_dest_i[i]) >= NUM_OUT;
         end
      end
      assign routed  = in_valid_i & ~oor;
      assign dropped = in_valid_i & oor;
      assign drop_o  = !rst_i && (|dropped);
   end else begin : g_wrap
      assign routed  = in_valid_i;
      assign dropped = '0;
      assign drop_o  = 1'b0;
   end

   always_comb begin
      req = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            req[j][i] = routed[i] && (eff_d[i] == DEST_W'(j));
         end
      end
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign load_ok[j] = !out_valid_o[j] || out_ready_i[j];
      assign xfer[j]    = !rst_i && load_ok[j] && (|req[j]);

      xbar_rr_arb #(
         .NUM_REQ (NUM_IN)
      ) u_arb (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .req_i     (req[j]),
         .adv_i     (xfer[j]),
         .gnt_o     (gnt[j]),
         .gnt_idx_o (gnt_idx[j])
      );
   end

   // Each input requests at most one output, so OR-ing across outputs is exact
   always_comb begin
      granted = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            granted[i] = granted[i] | (gnt[j][i] & load_ok[j]);
         end
      end
   end

   assign in_ready_o = rst_i ? '0 : (granted | dropped);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= '0;
         out_data_o  <= '0;
         out_src_o   <= '0;
      end else begin
         for (int j = 0; j < NUM_OUT; j++) begin
            if (xfer[j]) begin
               out_data_o[j]  <= in_data_i[gnt_idx[j]];
               out_src_o[j]   <= gnt_idx[j];
               out_valid_o[j] <= 1'b1;
            end else if (out_ready_i[j]) begin
               out_valid_o[j] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_xbar.sv
// Self-checking bench for stream_xbar (NUM_IN=4, NUM_OUT=6, ELEM_WIDTH=8).
// Honours STREAM_XBAR_DROP_EN the same way as the design build.
module tb_stream_xbar;

   localparam int NI = 4;
   localparam int NO = 6;
   localparam int EW = 8;
   localparam int DW = 3;
   localparam int SW = 2;
   localparam int BW = SW + EW;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NI-1:0][EW-1:0]  in_data;
   logic [NI-1:0][DW-1:0]  in_dest;
   logic [NI-1:0]          in_valid;
   logic [NI-1:0]          in_ready;
   logic [NO-1:0][EW-1:0]  out_data;
   logic [NO-1:0][SW-1:0]  out_src;
   logic [NO-1:0]          out_valid;
   logic [NO-1:0]          out_ready;
   logic                   drop;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] exp_q[NO][$];
   logic [BW-1:0] mon_exp;

   typedef struct {
      logic [NI-1:0]         valid;
      logic [NI-1:0][DW-1:0] dest;
      logic [NI-1:0][EW-1:0] data;
      logic [NI-1:0]         exp_ready;
   } vec_t;

   vec_t vecs[5];

   stream_xbar #(
      .ELEM_WIDTH (EW),
      .NUM_IN     (NI),
      .NUM_OUT    (NO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_data_i   (in_data),
      .in_dest_i   (in_dest),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_src_o   (out_src),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .drop_o      (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected output for a destination index; -1 means the beat is discarded
   function automatic int route(input logic [DW-1:0] dest);
      if (int'(dest) < NO) return int'(dest);
`ifdef STREAM_XBAR_DROP_EN
      return -1;
`else
      return int'(dest) - NO;
`endif
   endfunction

   // Scoreboard: every output handshake must match the oldest expected beat
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int j = 0; j < NO; j++) begin
            if (out_valid[j] && out_ready[j]) begin
               if (exp_q[j].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL out_beat_unexpected out=%0d actual=%0h required=none", j,
                           {out_src[j], out_data[j]});
               end else begin
                  mon_exp = exp_q[j].pop_front();
                  check($sformatf("out_beat[%0d]", j), 64'({out_src[j], out_data[j]}), 64'(mon_exp));
               end
            end
         end
      end
   end

   initial begin
      logic [1:0]    w;
      logic [NO-1:0] exp_ov;
      logic          exp_drop;
      int            d;

      rst       = 1'b1;
      in_valid  = '1;
      in_dest   = '0;
      in_data   = '0;
      out_ready = '1;

      // Reset held 2 cycles with every input valid
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("rst_in_ready", 64'(in_ready), 64'(0));
         check("rst_out_valid", 64'(out_valid), 64'(0));
         check("rst_out_data", 64'(out_data), 64'(0));
         check("rst_drop", 64'(drop), 64'(0));
         next_cycle();
      end
      rst      = 1'b0;
      in_valid = '0;

      // Contention on out1 from fresh pointers: strict 0,1,2,3 rotation
      in_dest  = {NI{3'd1}};
      for (int i = 0; i < NI; i++) in_data[i] = 8'(16 * (i + 1));
      in_valid = '1;
      for (int k = 0; k < 8; k++) begin
         w = 2'(k % NI);
         @(negedge clk);
         check("cont_ready", 64'(in_ready), 64'(4'b0001 << w));
         exp_q[1].push_back({w, in_data[w]});
         next_cycle();
         in_data[w] = in_data[w] + 8'd1;
      end
      in_valid = '0;
      next_cycle();
      next_cycle();

      // Single-cycle vectors with distinct destinations
      vecs[0].valid = 4'b1111; vecs[0].dest = {3'd2, 3'd3, 3'd4, 3'd5};
      vecs[0].data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; vecs[0].exp_ready = 4'b1111;
      vecs[1].valid = 4'b0101; vecs[1].dest = {3'd0, 3'd1, 3'd0, 3'd0};
      vecs[1].data  = {8'h00, 8'hC3, 8'h00, 8'h5C}; vecs[1].exp_ready = 4'b0101;
      vecs[2].valid = 4'b1010; vecs[2].dest = {3'd7, 3'd0, 3'd6, 3'd0};
      vecs[2].data  = {8'h77, 8'h00, 8'h66, 8'h00}; vecs[2].exp_ready = 4'b1010;
      vecs[3].valid = 4'b0000; vecs[3].dest = {3'd1, 3'd1, 3'd1, 3'd1};
      vecs[3].data  = {8'h01, 8'h02, 8'h03, 8'h04}; vecs[3].exp_ready = 4'b0000;
      vecs[4].valid = 4'b1111; vecs[4].dest = {3'd5, 3'd4, 3'd1, 3'd0};
      for (int i = 0; i < NI; i++) vecs[4].data[i] = 8'($urandom_range(0, 255));
      vecs[4].exp_ready = 4'b1111;

      for (int v = 0; v < 5; v++) begin
         in_valid = vecs[v].valid;
         in_dest  = vecs[v].dest;
         in_data  = vecs[v].data;
         @(negedge clk);
         check("vec_ready", 64'(in_ready), 64'(vecs[v].exp_ready));
         exp_drop = 1'b0;
         exp_ov   = '0;
         for (int i = 0; i < NI; i++) begin
            if (vecs[v].exp_ready[i]) begin
               d = route(vecs[v].dest[i]);
               if (d < 0) begin
                  exp_drop = 1'b1;
               end else begin
                  exp_q[d].push_back({2'(i), vecs[v].data[i]});
                  exp_ov[d] = 1'b1;
               end
            end
         end
         check("vec_drop", 64'(drop), 64'(exp_drop));
         next_cycle();
         in_valid = '0;
         @(negedge clk);
         check("vec_out_valid", 64'(out_valid), 64'(exp_ov));
         check("vec_drop_clear", 64'(drop), 64'(0));
         next_cycle();
      end

      // Backpressure on out2: 0x11 parked, 0x22 stalled, both delivered once
      out_ready = 6'b111011;
      in_dest   = {NI{3'd2}};
      in_data   = '0;
      in_data[1] = 8'h11;
      in_valid  = 4'b0010;
      @(negedge clk);
      check("bp_first_ready", 64'(in_ready), 64'(4'b0010));
      exp_q[2].push_back({2'd1, 8'h11});
      next_cycle();
      in_data[1] = 8'h22;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_stall_ready", 64'(in_ready), 64'(0));
         check("bp_hold_valid", 64'(out_valid[2]), 64'(1));
         check("bp_hold_data", 64'(out_data[2]), 64'(8'h11));
         next_cycle();
      end
      out_ready = '1;
      @(negedge clk);
      check("bp_release_ready", 64'(in_ready), 64'(4'b0010));
      exp_q[2].push_back({2'd1, 8'h22});
      next_cycle();
      in_valid = '0;
      @(negedge clk);
      check("bp_second_data", 64'(out_data[2]), 64'(8'h22));
      next_cycle();
      @(negedge clk);
      check("bp_no_duplicate", 64'(out_valid[2]), 64'(0));
      next_cycle();

      // Reset while out0 is full and stalled
      out_ready  = 6'b111110;
      in_dest    = {NI{3'd0}};
      in_data    = {8'h00, 8'h00, 8'hB1, 8'h5A};
      in_valid   = 4'b0001;
      @(negedge clk);
      check("mid_fill_ready", 64'(in_ready), 64'(4'b0001));
      next_cycle();
      rst        = 1'b1;
      in_data[0] = 8'h5B;
      in_valid   = 4'b0011;
      @(negedge clk);
      check("mid_rst_ready", 64'(in_ready), 64'(0));
      next_cycle();
      rst       = 1'b0;
      out_ready = '1;
      @(negedge clk);
      check("mid_out_valid", 64'(out_valid[0]), 64'(0));
      check("mid_ptr_reset", 64'(in_ready), 64'(4'b0001));
      exp_q[0].push_back({2'd0, 8'h5B});
      next_cycle();
      in_valid = 4'b0010;
      @(negedge clk);
      check("mid_second_ready", 64'(in_ready), 64'(4'b0010));
      exp_q[0].push_back({2'd1, 8'hB1});
      next_cycle();
      in_valid = '0;
      next_cycle();
      next_cycle();

      for (int j = 0; j < NO; j++) begin
         check($sformatf("queue_empty[%0d]", j), 64'(exp_q[j].size()), 64'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
